// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data-stage port share
// one single-outstanding memory port. The data stage normally wins a
// simultaneous request, but after STARVE_LIM back-to-back data-stage wins with
// fetch waiting, the next tie goes to fetch.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction in flight; grants are issued combinationally
// BUSY_IF | fetch read issued on m_*, waiting for m_ack
// BUSY_ME | data-stage read/write issued on m_*, waiting for m_ack
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  // data-stage port
  input  logic          me_req,
  input  logic          me_we,
  input  logic [AW-1:0] me_addr,
  input  logic [31:0]   me_wdata,
  input  logic [3:0]    me_be,
  output logic          me_gnt,
  output logic          me_rvalid,
  output logic [31:0]   me_rdata,
  // memory port
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_be,
  input  logic          m_ack,
  input  logic [31:0]   m_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_ME = 2'd2
  } state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t     state_q, state_d;
  logic [3:0] streak_q;
  logic       fetch_turn;

  // Fetch takes a tie only once the data stage has used up its streak.
  assign fetch_turn = (streak_q == LIM);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and combinational grants; grants exist only in IDLE.
  always_comb begin
    state_d = state_q;
    if_gnt  = 1'b0;
    me_gnt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req && (!me_req || fetch_turn)) begin
          if_gnt  = 1'b1;
          state_d = BUSY_IF;
        end else if (me_req) begin
          me_gnt  = 1'b1;
          state_d = BUSY_ME;
        end
      end
      BUSY_IF, BUSY_ME: begin
        if (m_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Count data-stage wins that left fetch waiting; saturate at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (if_gnt) begin
      streak_q <= '0;
    end else if (me_gnt) begin
      if (!if_req)              streak_q <= '0;
      else if (streak_q != LIM) streak_q <= streak_q + 4'd1;
    end
  end

  // Memory command register and read-return path. An ack outside a busy
  // state is ignored; the command fields hold their last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_be      <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      me_rvalid <= 1'b0;
      me_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      me_rvalid <= 1'b0;
      if (if_gnt) begin
        m_req   <= 1'b1;
        m_we    <= 1'b0;
        m_addr  <= if_addr;
        m_wdata <= '0;
        m_be    <= 4'hF;
      end else if (me_gnt) begin
        m_req   <= 1'b1;
        m_we    <= me_we;
        m_addr  <= me_addr;
        m_wdata <= me_wdata;
        m_be    <= me_be;
      end else if (m_ack && (state_q != IDLE)) begin
        m_req <= 1'b0;
        if (state_q == BUSY_IF) begin
          if_rvalid <= 1'b1;
          if_rdata  <= m_rdata;
        end else begin
          me_rvalid <= 1'b1;
          me_rdata  <= m_we ? 32'h0 : m_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized request/ack phase. Expected read returns are queued at grant time
// and retired when an rvalid appears.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, me_req, me_we;
  logic [AW-1:0] if_addr, me_addr;
  logic [31:0]   me_wdata;
  logic [3:0]    me_be;
  logic          if_gnt, if_rvalid, me_gnt, me_rvalid;
  logic [31:0]   if_rdata, me_rdata;
  logic          m_req, m_we, m_ack;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;
  logic [3:0]    m_be;

  // memory responder controls
  logic        mem_auto  = 1'b1;
  logic        auto_ack  = 1'b0;
  logic [31:0] auto_rdata = 32'h0;
  logic        man_ack   = 1'b0;
  logic        spur_en   = 1'b0;
  logic        rand_mode = 1'b0;
  int          ack_delay = 0;
  int          ack_cnt   = 0;

  assign m_ack   = mem_auto ? auto_ack : man_ack;
  assign m_rdata = auto_rdata;

  typedef struct {
    bit          is_me;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;
  logic if_g = 1'b0, me_g = 1'b0;

  mem_port_arbiter #(.AW(AW), .STARVE_LIM(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .me_req(me_req), .me_we(me_we), .me_addr(me_addr), .me_wdata(me_wdata),
    .me_be(me_be), .me_gnt(me_gnt), .me_rvalid(me_rvalid), .me_rdata(me_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return (a ^ 32'h5A5A_0000) + 32'h11;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: ack ack_delay cycles after m_req is first seen.
  always @(negedge clk) begin
    auto_ack = 1'b0;
    if (m_req) begin
      if (ack_cnt >= ack_delay) begin
        auto_ack   = 1'b1;
        auto_rdata = mem_fn(m_addr);
        ack_cnt    = 0;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
      if (spur_en && $urandom_range(0, 7) == 0) begin
        auto_ack   = 1'b1;
        auto_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Scoreboard retirement on every rvalid.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (if_rvalid || me_rvalid)) begin
      chk("rvalid_exclusive", 32'(if_rvalid & me_rvalid), 32'h0);
      chk("rvalid_expected", 32'(sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rvalid_owner", 32'(me_rvalid), 32'(e.is_me));
        chk("rdata", me_rvalid ? me_rdata : if_rdata, e.data);
      end
    end
  end

  // Advance to the next sampling point; a granted requester drops its request.
  task automatic cyc();
    @(negedge clk);
    if (if_g) if_req = 1'b0;
    if (me_g) me_req = 1'b0;
    if_g = 1'b0;
    me_g = 1'b0;
  endtask

  // Observe the combinational grants for the inputs just driven.
  task automatic look();
    #1;
    chk("gnt_exclusive", 32'(if_gnt & me_gnt), 32'h0);
    chk("no_gnt_busy", 32'((if_gnt | me_gnt) & m_req), 32'h0);
    if_g = if_gnt;
    me_g = me_gnt;
    if (if_gnt) sb.push_back('{1'b0, mem_fn(if_addr)});
    if (me_gnt) sb.push_back('{1'b1, me_we ? 32'h0 : mem_fn(me_addr)});
    if (rand_mode && (if_gnt || me_gnt)) ack_delay = $urandom_range(0, 3);
  endtask

  task automatic drain();
    int k = 0;
    while ((m_req || sb.size() != 0) && k < 40) begin
      cyc();
      look();
      k++;
    end
    chk("drain_done", 32'(m_req || sb.size() != 0), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ng;
    int  starve;
    bit  got;

    rst_n = 1'b0; if_req = 1'b0; me_req = 1'b0; me_we = 1'b0;
    if_addr = '0; me_addr = '0; me_wdata = '0; me_be = '0;

    // reset values
    cyc(); cyc();
    chk("rst_m_req", 32'(m_req), 32'h0);
    chk("rst_m_we", 32'(m_we), 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_m_be", 32'(m_be), 32'h0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
    chk("rst_me_rvalid", 32'(me_rvalid), 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_me_rdata", me_rdata, 32'h0);

    // fetch alone, granted in the first cycle out of reset, ack after 2
    rst_n = 1'b1;
    ack_delay = 2;
    if_req = 1'b1; if_addr = 32'h100;
    look();
    chk("if_only_gnt", 32'(if_g), 32'h1);
    chk("if_only_me_gnt", 32'(me_g), 32'h0);
    cyc();
    chk("if_m_req", 32'(m_req), 32'h1);
    chk("if_m_addr", m_addr, 32'h100);
    chk("if_m_we", 32'(m_we), 32'h0);
    chk("if_m_be", 32'(m_be), 32'hF);
    chk("if_m_wdata", m_wdata, 32'h0);
    cyc();
    chk("if_m_req_hold", 32'(m_req), 32'h1);
    cyc();
    chk("if_rvalid_early", 32'(if_rvalid), 32'h0);
    cyc();
    chk("if_rvalid_t4", 32'(if_rvalid), 32'h1);
    chk("if_rdata_t4", if_rdata, 32'h13);
    chk("if_m_req_drop", 32'(m_req), 32'h0);
    cyc();
    chk("if_rvalid_pulse", 32'(if_rvalid), 32'h0);
    chk("if_rdata_hold", if_rdata, 32'h13);

    // both request: ME write wins, IF granted in the ME rvalid cycle
    cyc();
    ack_delay = 1;
    if_req = 1'b1; if_addr = 32'h300;
    me_req = 1'b1; me_we = 1'b1; me_addr = 32'h200; me_be = 4'b0011; me_wdata = 32'hDEAD_BEEF;
    look();
    chk("tie_me_gnt", 32'(me_g), 32'h1);
    chk("tie_if_gnt", 32'(if_g), 32'h0);
    cyc();
    chk("wr_m_we", 32'(m_we), 32'h1);
    chk("wr_m_addr", m_addr, 32'h200);
    chk("wr_m_be", 32'(m_be), 32'h3);
    chk("wr_m_wdata", m_wdata, 32'hDEAD_BEEF);
    look();
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cyc();
      look();
      if (me_rvalid) begin
        got = 1'b1;
        chk("wr_me_rdata", me_rdata, 32'h0);
        chk("b2b_if_gnt", 32'(if_g), 32'h1);
      end
    end
    chk("wr_me_rvalid_seen", 32'(got), 32'h1);
    drain();

    // starvation limit with both held and immediate ack
    ack_delay = 0;
    ng = 0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      cyc();
      if_req = 1'b1; if_addr = 32'h500;
      me_req = 1'b1; me_we = 1'b0; me_addr = 32'h600;
      look();
      if (if_g || me_g) begin
        chk($sformatf("starve_order_%0d", ng), 32'(me_g), 32'((ng % 5) != 4));
        ng++;
      end
    end
    chk("starve_grants", 32'(ng), 32'd10);
    cyc();
    if_req = 1'b0; me_req = 1'b0;
    drain();

    // reset while BUSY_ME; late ack must not complete the abandoned read
    mem_auto = 1'b0;
    cyc();
    me_req = 1'b1; me_we = 1'b0; me_addr = 32'h400;
    look();
    chk("rst_tx_gnt", 32'(me_g), 32'h1);
    cyc();
    chk("rst_tx_m_req", 32'(m_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_m_req", 32'(m_req), 32'h0);
    chk("async_m_addr", m_addr, 32'h0);
    sb.delete();
    #1;
    rst_n = 1'b1;
    cyc();
    man_ack = 1'b1;
    look();
    cyc();
    man_ack = 1'b0;
    look();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("abandon_no_rvalid", 32'(me_rvalid | if_rvalid), 32'h0);
    end

    // spurious ack in IDLE
    cyc();
    man_ack = 1'b1;
    look();
    cyc();
    man_ack = 1'b0;
    chk("spur_m_req", 32'(m_req), 32'h0);
    cyc();
    chk("spur_no_rvalid", 32'(me_rvalid | if_rvalid), 32'h0);

    // normal transaction after reset and spurious ack
    mem_auto = 1'b1;
    ack_delay = 1;
    me_req = 1'b1; me_we = 1'b0; me_addr = 32'h40C;
    look();
    chk("post_rst_gnt", 32'(me_g), 32'h1);
    drain();

    // randomized traffic
    rand_mode = 1'b1;
    spur_en   = 1'b1;
    starve    = 0;
    for (int i = 0; i < 10000; i++) begin
      cyc();
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!me_req && $urandom_range(0, 2) == 0) begin
        me_req = 1'b1; me_we = 1'($urandom_range(0, 1)); me_addr = $urandom;
        me_wdata = $urandom; me_be = 4'($urandom_range(0, 15));
      end
      look();
      if (if_g)      starve = 0;
      else if (me_g) starve = if_req ? starve + 1 : 0;
      if (if_g || me_g) chk("starve_bound", 32'(starve <= LIMIT), 32'h1);
    end
    spur_en   = 1'b0;
    rand_mode = 1'b0;
    ack_delay = 0;
    while (if_req || me_req) begin
      cyc();
      look();
    end
    drain();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
